// File: rtl/tile_pick_conditioner.sv
// ============================================================================
//  Module   : tile_pick_conditioner
//  Brief    : Debounced select press -> validated single-cycle tile pick event.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tile_pick_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        selectSW,
    input  logic [9:0]  SW,
    input  logic [9:0]  taken_mask,
    input  logic        enable,
    output logic        pick_valid,
    output logic [3:0]  pick_idx,
    output logic [9:0]  pick_onehot,
    output logic        pick_reject,
    output logic        sel_level
);

    localparam logic [2:0] S_UNARMED = 3'd0;
    localparam logic [2:0] S_HI      = 3'd1;
    localparam logic [2:0] S_WAIT_LO = 3'd2;
    localparam logic [2:0] S_LO      = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sel_s1, r_sel_s2;
    logic [9:0]       r_sw_s1, r_sw_s2;
    logic [2:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             w_cnt_last;
    logic             w_press;
    logic [9:0]       w_lowest;
    logic [3:0]       w_k;
    logic             w_ok;

    // Select idles high, so its synchronizer resets high to avoid a false low.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_sel_s1 <= 1'b1;
            r_sel_s2 <= 1'b1;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_sel_s1 <= selectSW;
            r_sel_s2 <= r_sel_s1;
            r_sw_s1  <= SW;
            r_sw_s2  <= r_sw_s1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_UNARMED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_cnt_last = (r_cnt == c_LAST);
    assign w_cnt_inc  = w_cnt_last ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        case (r_state)
            S_UNARMED: begin
                if (!r_sel_s2) begin
                    w_cnt_nxt = '0;
                end else if (w_cnt_last) begin
                    w_state_nxt = S_HI;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_HI: begin
                if (!r_sel_s2) begin
                    w_state_nxt = S_WAIT_LO;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT_LO: begin
                if (r_sel_s2) begin
                    w_state_nxt = S_HI;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_last) begin
                    w_state_nxt = S_LO;
                    w_cnt_nxt   = '0;
                    w_press     = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_LO: begin
                if (r_sel_s2) begin
                    w_state_nxt = S_WAIT_HI;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT_HI: begin
                if (!r_sel_s2) begin
                    w_state_nxt = S_LO;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_last) begin
                    w_state_nxt = S_HI;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_UNARMED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        sel_level = !((r_state == S_LO) || (r_state == S_WAIT_HI));
    end

    // Only the lowest raised switch is considered; a taken one rejects outright.
    assign w_lowest = r_sw_s2 & (~r_sw_s2 + 10'd1);
    assign w_ok     = (|w_lowest) && !(|(w_lowest & taken_mask));

    always_comb begin
        w_k = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (r_sw_s2[i]) w_k = 4'(i);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            pick_valid  <= 1'b0;
            pick_reject <= 1'b0;
            pick_idx    <= '0;
            pick_onehot <= '0;
        end else begin
            pick_valid  <= 1'b0;
            pick_reject <= 1'b0;
            if (w_press && enable) begin
                if (w_ok) begin
                    pick_valid  <= 1'b1;
                    pick_idx    <= w_k;
                    pick_onehot <= w_lowest;
                end else begin
                    pick_reject <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/tile_pick_conditioner.md
Name: tile_pick_conditioner

Overview:
- Upstream input stage for the in-game tile-matching FSM.
- Synchronizes and debounces the raw selectSW switch, detects a debounced press (1->0 transition), and samples the synchronized SW[9:0] bank at that instant.
- Emits a single-cycle, validated tile-pick event to the FSM, so the FSM never edge-detects raw inputs.
- Picks of already-matched tiles, and presses with no switch up, produce a reject pulse instead of a pick.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles the synchronized select level must hold before it is accepted (20 ms at 50 MHz)
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
selectSW  input  1  raw select switch, asynchronous; a 1->0 transition is a press
SW  input  10  raw tile switches, asynchronous
taken_mask  input  10  tiles already matched (bit i = tile i unavailable), synchronous to CLOCK_50
enable  input  1  inGameOn; events are suppressed while low
pick_valid  output  1  one-cycle pulse: valid tile picked
pick_idx  output  4  index 0..9 of the picked tile, held until the next pick_valid
pick_onehot  output  10  1<<pick_idx, held with pick_idx
pick_reject  output  1  one-cycle pulse: press accepted but no eligible tile
sel_level  output  1  current debounced select level

Behaviour:
- Reset (async, resetn=0): selectSW sync flops = 1; SW sync flops = 0; counter = 0; state = UNARMED.
- Output reset values: pick_valid = 0, pick_reject = 0, pick_idx = 0, pick_onehot = 0, sel_level = 1.
- Synchronization: two-flop synchronizers on selectSW and on each SW bit; s denotes the synchronized selectSW.
- Debounce FSM:
  - UNARMED: s=1 counts; s=0 clears the counter. At cnt==DEBOUNCE_CYCLES-1 -> HI, sel_level=1. This blocks any event when the switch is already low at reset release.
  - HI: s=0 -> WAIT_LO, cnt=0.
  - WAIT_LO: s=1 -> HI (glitch rejected, no event). Else at cnt==DEBOUNCE_CYCLES-1 -> LO, sel_level=0, press event. Else cnt++.
  - LO: s=1 -> WAIT_HI, cnt=0.
  - WAIT_HI: s=0 -> LO. Else at cnt==DEBOUNCE_CYCLES-1 -> HI, sel_level=1 (release, no event). Else cnt++.
- Press event (registered, asserted in the first cycle state==LO), only if enable=1:
  - k = lowest set bit of synchronized SW.
  - No bit set: pick_reject=1.
  - taken_mask[k]=1: pick_reject=1. Higher switches are not searched.
  - Otherwise: pick_valid=1, pick_idx=k, pick_onehot=1<<k.
- pick_valid and pick_reject are mutually exclusive, each exactly 1 cycle, at most one per press.
- Latency: a raw 1->0 on selectSW held stable produces the event exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples raw low.
- enable=0: the FSM still tracks the switch level; no pulses. Raising enable while in LO/WAIT_HI does not fire; the next full press is required.
- SW and taken_mask changing during debounce: only values in the event cycle matter.
- Counter never wraps: it is cleared on every state change and saturates at DEBOUNCE_CYCLES-1.
- Reset mid-debounce: aborts with no pulse; returns to UNARMED.

Test Plan:
- DEBOUNCE_CYCLES=4; reset with selectSW=1, hold 10 cycles, SW=0000000100, taken_mask=0, enable=1; drive selectSW 1->0 and hold -> pick_valid high exactly 1 cycle at edge 7 after the drop, pick_idx=2, pick_onehot=0000000100, pick_reject=0.
- Glitch: selectSW low 2 cycles then high -> no pick_valid/pick_reject; sel_level stays 1. Release bounce (high 2 cycles, back low) -> no second event.
- SW=1000010000, taken_mask=0000010000 -> pick_reject pulse, no pick_valid; with taken_mask=0 -> pick_idx=4. SW=0 -> pick_reject.
- selectSW held 0 through reset release -> no event ever while held; after release (>=4 cycles high) and a new press, exactly one pick_valid.
- enable=0 during press -> no pulses. enable raised while still held low -> none. Release, press again -> pick_valid.
- Assert resetn=0 mid WAIT_LO -> all outputs return to reset values immediately (async); no pulse afterward until a full armed press.
